revaluate_controller: RTL
=========================

# revaluate_controller

Sequencer for the revaluate output stage of the encoder. Walks the 25×64-bit state (1600 bits) one bit per accepted cycle and drives the revaluate file writer: an open pulse, a per-bit write enable, and the row-end and last-row flags. Can repeat the walk for several passes, one writer file per pass. Sits between the top-level encoder controller (start/done) and the serial revaluate datapath plus file writer.

## Interface
- ROW_LEN, 25: bits per row; row-end flag when the column counter wraps.
- N_ROWS, 64: rows per pass.
- N_PASSES, 1: full walks per start.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- src_valid  in  1  datapath bit available this cycle; counters advance only when high in RUN.
- busy  out  1  high in every state except IDLE.
- wr_start  out  1  one-cycle pulse to the writer to open its file (OPEN state).
- en  out  1  writer/datapath bit enable = (state==RUN) & src_valid.
- col  out  $clog2(ROW_LEN)  current bit index in row, 0..ROW_LEN-1.
- row  out  $clog2(N_ROWS)  current row, 0..N_ROWS-1.
- pass  out  max(1,$clog2(N_PASSES))  current pass index.
- co_c25  out  1  en & (col==ROW_LEN-1); writer emits newline.
- co_c64  out  1  (state==RUN) & (row==N_ROWS-1); with co_c25, writer closes file.
- done  out  1  one-cycle pulse after the final pass completes.

## Operation
- States: IDLE, OPEN, RUN, DONE (registered, one-hot or binary).
- IDLE: counters held at 0. start=1 → OPEN.
- OPEN: exactly one cycle, wr_start=1 → RUN.
- RUN with src_valid=1: col increments. At col==ROW_LEN-1, col→0 and row increments. At (row==N_ROWS-1, col==ROW_LEN-1) the pass ends: row→0, col→0.
  - If pass<N_PASSES-1: pass increments, state → OPEN.
  - Otherwise: state → DONE.
- RUN with src_valid=0: counters and state hold; en=0, co_c25=0.
- DONE: exactly one cycle, done=1, pass→0 → IDLE.
- start outside IDLE is ignored; it is not queued.
- start in the DONE cycle is ignored. A new run needs start in IDLE.
- All outputs are decoded from registered state and counters plus src_valid. No other combinational input paths.

## Timing
- Reset (rst=1 at a clock edge): state=IDLE, col=0, row=0, pass=0. busy, wr_start, en, co_c25, co_c64, done all 0.
- Reset mid-RUN aborts immediately. No done, no wr_start. The writer's open file is left to the top level.
- start sampled at edge k → OPEN at cycles k..k+1 (wr_start high). First en possible in the next cycle.
- With src_valid held high and N_PASSES=1: 1 OPEN cycle + 1600 RUN cycles + 1 DONE cycle.
  - start at edge 0 → done high at cycle 1602 → IDLE at 1603.
- Each additional pass adds 1 OPEN + 1600 RUN cycles.
- The final-bit cycle has en=1, co_c25=1, co_c64=1 together, exactly once per pass.
- co_c25 fires N_ROWS times per pass.
- src_valid gaps stretch RUN without changing the counter sequence.

## Structure
- Shared package revaluate_pkg holds:
  - ROW_LEN_DEF=25, N_ROWS_DEF=64.
  - state typedef {IDLE, OPEN, RUN, DONE}.
- Sub-module revaluate_wrap_counter, instantiated twice (col, row):
  - Parameter MAX; inputs clk, rst, clr, inc.
  - Outputs value and wrap = inc & (value==MAX-1).
  - The row counter's inc is the col counter's wrap.
- Pass counter and FSM are inline in revaluate_controller.

## Test plan
- Reset then idle: rst high 2 cycles, start=0 → all outputs 0, col=row=pass=0, busy=0 for 10 cycles.
- Single pass, src_valid=1: start pulse at cycle 0 → wr_start at cycle 1; en high cycles 2..1601; co_c25 exactly 64 times; co_c64&co_c25 once, at cycle 1601; done at cycle 1602; busy=0 at 1603.
- Backpressure: src_valid toggles 1,0 → en count is still 1600, counter sequence is unchanged, done arrives at cycle 3201 ±1 per the exact pattern.
- N_PASSES=3: one start → 3 wr_start pulses, each followed by 1600 en cycles; pass reads 0,1,2; a single done.
- Reset mid-run: rst at row=10, col=7 → next cycle IDLE, all outputs 0, no done; a new start gives a normal full pass.
- start while busy: extra start pulses in RUN and DONE → ignored; exactly one done; no second OPEN.

Source files
------------

// File: rtl/revaluate_pkg.sv
// Shared constants and FSM state type for the revaluate output-stage sequencer.
package revaluate_pkg;

    localparam int ROW_LEN_DEF = 25;
    localparam int N_ROWS_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/revaluate_wrap_counter.sv
// Modulo-MAX up-counter with a combinational wrap flag, used for the column and row indices.
module revaluate_wrap_counter #(
    parameter int  MAX = 25,
    localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign wrap  = inc & (value_q == W'(MAX - 1));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = wrap ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/revaluate_controller.sv
// Sequencer that walks the state one bit per accepted cycle and drives the revaluate file writer,
// optionally repeating the walk for several passes (one writer file per pass).
module revaluate_controller
    import revaluate_pkg::*;
#(
    parameter int  ROW_LEN  = ROW_LEN_DEF,
    parameter int  N_ROWS   = N_ROWS_DEF,
    parameter int  N_PASSES = 1,
    localparam int CW = $clog2(ROW_LEN),
    localparam int RW = $clog2(N_ROWS),
    localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          src_valid,
    output logic          busy,
    output logic          wr_start,
    output logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [PW-1:0] pass,
    output logic          co_c25,
    output logic          co_c64,
    output logic          done
);

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] pass_q;
    logic [PW-1:0] pass_d;
    logic          col_wrap;
    logic          row_wrap;
    logic          cnt_clr;

    // Counters only move in RUN; outside it they are forced back to zero.
    assign cnt_clr = (state_q != RUN);
    assign en      = (state_q == RUN) & src_valid;

    revaluate_wrap_counter #(.MAX(ROW_LEN)) u_col_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (en),
        .value (col),
        .wrap  (col_wrap)
    );

    revaluate_wrap_counter #(.MAX(N_ROWS)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (col_wrap),
        .value (row),
        .wrap  (row_wrap)
    );

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                pass_d = '0;
                if (start) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                state_d = RUN;
            end
            RUN: begin
                // row_wrap marks the final bit of the pass being accepted.
                if (row_wrap) begin
                    if (pass_q == PW'(N_PASSES - 1)) begin
                        state_d = DONE;
                    end else begin
                        pass_d  = pass_q + PW'(1);
                        state_d = OPEN;
                    end
                end
            end
            DONE: begin
                pass_d  = '0;
                state_d = IDLE;
            end
            default: begin
                pass_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign wr_start = (state_q == OPEN);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign co_c25   = en & (col == CW'(ROW_LEN - 1));
    assign co_c64   = (state_q == RUN) & (row == RW'(N_ROWS - 1));

endmodule
